// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller:
// opcode and condition-code constants plus the FSM state encoding.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] OPC_ADD   = 4'h0;
    localparam logic [3:0] OPC_SUB   = 4'h1;
    localparam logic [3:0] OPC_AND   = 4'h2;
    localparam logic [3:0] OPC_OR    = 4'h3;
    localparam logic [3:0] OPC_XOR   = 4'h4;
    localparam logic [3:0] OPC_NOT   = 4'h5;
    localparam logic [3:0] OPC_SHL   = 4'h6;
    localparam logic [3:0] OPC_SHR   = 4'h7;
    localparam logic [3:0] OPC_ADDI  = 4'h8;
    localparam logic [3:0] OPC_LOAD  = 4'h9;
    localparam logic [3:0] OPC_STORE = 4'hA;
    localparam logic [3:0] OPC_CMP   = 4'hB;
    localparam logic [3:0] OPC_MOV   = 4'hC;
    localparam logic [3:0] OPC_BEQ   = 4'hD;
    localparam logic [3:0] OPC_JMP   = 4'hE;
    localparam logic [3:0] OPC_NOP   = 4'hF;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        RESP
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response bundle between the two ALU requesters and the
// issue controller; master is the requester side.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 7
);
    logic              req0_valid;
    logic              req0_ready;
    logic [3:0]        req0_opcode;
    logic [DATA_W-1:0] req0_op1;
    logic [DATA_W-1:0] req0_op2;
    logic [IMM_W-1:0]  req0_imm;
    logic [3:0]        req0_cond;

    logic              req1_valid;
    logic              req1_ready;
    logic [3:0]        req1_opcode;
    logic [DATA_W-1:0] req1_op1;
    logic [DATA_W-1:0] req1_op2;
    logic [IMM_W-1:0]  req1_imm;
    logic [3:0]        req1_cond;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_executed;

    modport master (
        output req0_valid, req0_opcode, req0_op1, req0_op2, req0_imm, req0_cond,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_op1, req1_op2, req1_imm, req1_cond,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_executed,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_op1, req0_op2, req0_imm, req0_cond,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_op1, req1_op2, req1_imm, req1_cond,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_executed,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_issue_ctrl_cond_check.sv
// ARM-style condition evaluation against NZCV flags.
// Codes 14 and 15 both mean "always".
module alu_issue_ctrl_cond_check
    import alu_issue_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    input  logic       v,
    output logic       pass
);

    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Round-robin issue controller sharing one registered ALU between
// two requesters, with conditional execution on the ALU flags.
module alu_issue_ctrl #(
    parameter int         DATA_W  = 16,
    parameter int         IMM_W   = 7,
    parameter logic [3:0] OPC_NOP = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [IMM_W-1:0]  alu_imm,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v
);
    import alu_issue_ctrl_pkg::*;

    state_t            state;
    state_t            state_next;
    logic              rr_ptr;
    logic              both;
    logic              any_valid;
    logic              gnt_id;
    logic              accept;
    logic              cond_pass;

    logic [3:0]        sel_opcode;
    logic [3:0]        sel_cond;
    logic [DATA_W-1:0] sel_op1;
    logic [DATA_W-1:0] sel_op2;
    logic [IMM_W-1:0]  sel_imm;

    logic              lat_id;
    logic              lat_pass;
    logic [3:0]        lat_opcode;
    logic [DATA_W-1:0] lat_op1;
    logic [DATA_W-1:0] lat_op2;
    logic [IMM_W-1:0]  lat_imm;

    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign both      = bus.req0_valid & bus.req1_valid;
    assign gnt_id    = both ? rr_ptr : bus.req1_valid;

    always_comb begin
        sel_opcode = bus.req0_opcode;
        sel_cond   = bus.req0_cond;
        sel_op1    = bus.req0_op1;
        sel_op2    = bus.req0_op2;
        sel_imm    = bus.req0_imm;
        if (gnt_id) begin
            sel_opcode = bus.req1_opcode;
            sel_cond   = bus.req1_cond;
            sel_op1    = bus.req1_op1;
            sel_op2    = bus.req1_op2;
            sel_imm    = bus.req1_imm;
        end
    end

    // Flags sampled here already include the previous op's EXEC update.
    alu_issue_ctrl_cond_check u_cond (
        .cond (sel_cond),
        .n    (alu_n),
        .z    (alu_z),
        .c    (alu_c),
        .v    (alu_v),
        .pass (cond_pass)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        bus.rsp_valid = 1'b0;
        alu_opcode    = OPC_NOP;
        alu_op1       = '0;
        alu_op2       = '0;
        alu_imm       = '0;
        case (state)
            IDLE: begin
                if (any_valid && !rst) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (lat_pass) begin
                    alu_opcode = lat_opcode;
                    alu_op1    = lat_op1;
                    alu_op2    = lat_op2;
                    alu_imm    = lat_imm;
                end
                state_next = CAPT;
            end
            CAPT: state_next = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req0_ready = accept & ~gnt_id;
    assign bus.req1_ready = accept & gnt_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr           <= 1'b0;
            lat_id           <= 1'b0;
            lat_pass         <= 1'b0;
            lat_opcode       <= OPC_NOP;
            lat_op1          <= '0;
            lat_op2          <= '0;
            lat_imm          <= '0;
            bus.rsp_id       <= 1'b0;
            bus.rsp_result   <= '0;
            bus.rsp_executed <= 1'b0;
        end else begin
            if (accept) begin
                lat_id     <= gnt_id;
                lat_pass   <= cond_pass;
                lat_opcode <= sel_opcode;
                lat_op1    <= sel_op1;
                lat_op2    <= sel_op2;
                lat_imm    <= sel_imm;
                if (both) begin
                    rr_ptr <= ~rr_ptr;
                end
            end
            if (state == CAPT) begin
                bus.rsp_id       <= lat_id;
                bus.rsp_result   <= lat_pass ? alu_result : '0;
                bus.rsp_executed <= lat_pass;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural registered ALU
// standing in for simple_proc_alu.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    typedef struct packed {
        logic        id;
        logic [15:0] res;
        logic        exe;
    } exp_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] r;
        logic [3:0]  f;
    } alu_o_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_op1;
    logic [15:0] alu_op2;
    logic [6:0]  alu_imm;
    logic [15:0] alu_result;
    logic        alu_n, alu_z, alu_c, alu_v;

    logic [15:0] alu_res_q = 16'h0;
    logic [3:0]  alu_flg_q = 4'h0;
    alu_o_t      ao;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [3:0]  mflags = 4'h0;
    bit          mrr = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    alu_issue_ctrl_if #(.DATA_W(16), .IMM_W(7)) bus ();

    alu_issue_ctrl #(
        .DATA_W (16),
        .IMM_W  (7),
        .OPC_NOP(4'hF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .alu_opcode(alu_opcode),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .alu_imm   (alu_imm),
        .alu_result(alu_result),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .alu_c     (alu_c),
        .alu_v     (alu_v)
    );

    always #5 clk = ~clk;

    // f is {n,z,c,v}; C is carry-out on add and not-borrow on subtract.
    function automatic alu_o_t alu_f(input logic [3:0] opc,
                                     input logic [15:0] a,
                                     input logic [15:0] b,
                                     input logic [3:0] f);
        alu_o_t      o;
        logic [16:0] s;
        o.wr = 1'b0;
        o.r  = 16'h0;
        o.f  = f;
        s    = 17'h0;
        case (opc)
            OPC_ADD: begin
                s    = {1'b0, a} + {1'b0, b};
                o.wr = 1'b1;
                o.r  = s[15:0];
                o.f  = {s[15], s[15:0] == 16'h0, s[16],
                        (a[15] == b[15]) && (s[15] != a[15])};
            end
            OPC_SUB, OPC_CMP: begin
                s    = {1'b0, a} - {1'b0, b};
                o.wr = 1'b1;
                o.r  = s[15:0];
                o.f  = {s[15], s[15:0] == 16'h0, ~s[16],
                        (a[15] != b[15]) && (s[15] != a[15])};
            end
            OPC_MOV: begin
                o.wr = 1'b1;
                o.r  = a;
                o.f  = {a[15], a == 16'h0, f[1], f[0]};
            end
            default: ;
        endcase
        return o;
    endfunction

    function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return c && !z;
            4'd9:    return !c || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        ao = alu_f(alu_opcode, alu_op1, alu_op2, alu_flg_q);
        if (ao.wr) alu_res_q <= ao.r;
        alu_flg_q <= ao.f;
    end

    assign alu_result = alu_res_q;
    assign {alu_n, alu_z, alu_c, alu_v} = alu_flg_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
                chk("rsp_result", 32'(bus.rsp_result), 32'(mon_e.res));
                chk("rsp_executed", 32'(bus.rsp_executed), 32'(mon_e.exe));
            end
        end
    end

    task automatic set_req(input bit id, input logic [3:0] opc, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] cond);
        if (id) begin
            bus.req1_opcode = opc;
            bus.req1_op1    = a;
            bus.req1_op2    = b;
            bus.req1_imm    = a[6:0];
            bus.req1_cond   = cond;
            bus.req1_valid  = 1'b1;
        end else begin
            bus.req0_opcode = opc;
            bus.req0_op1    = a;
            bus.req0_op2    = b;
            bus.req0_imm    = a[6:0];
            bus.req0_cond   = cond;
            bus.req0_valid  = 1'b1;
        end
    endtask

    task automatic predict(input bit id);
        logic [3:0]  opc, cond;
        logic [15:0] a, b;
        exp_t        e;
        alu_o_t      o;
        opc  = id ? bus.req1_opcode : bus.req0_opcode;
        cond = id ? bus.req1_cond : bus.req0_cond;
        a    = id ? bus.req1_op1 : bus.req0_op1;
        b    = id ? bus.req1_op2 : bus.req0_op2;
        e.id  = id;
        e.exe = cond_ok(cond, mflags);
        e.res = 16'h0;
        if (e.exe) begin
            o      = alu_f(opc, a, b, mflags);
            mflags = o.f;
            e.res  = o.r;
        end
        exp_q.push_back(e);
    endtask

    task automatic wait_gnt(input bit id);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("gnt_timeout", 0, 1);
        else chk(id ? "gnt_req1" : "gnt_req0",
                 32'({bus.req1_ready, bus.req0_ready}), id ? 32'd2 : 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_one(input bit id, input logic [3:0] opc, input logic [15:0] a,
                             input logic [15:0] b, input logic [3:0] cond);
        set_req(id, opc, a, b, cond);
        predict(id);
        wait_gnt(id);
        if (id) bus.req1_valid = 1'b0;
        else bus.req0_valid = 1'b0;
    endtask

    task automatic drive_both(input int n);
        bit g;
        set_req(1'b0, OPC_ADD, 16'h0100, 16'h0001, COND_AL);
        set_req(1'b1, OPC_SUB, 16'h0200, 16'h0001, COND_AL);
        for (int k = 0; k < n; k++) begin
            g = mrr;
            predict(g);
            wait_gnt(g);
            mrr = ~mrr;
            if (g) bus.req1_op1 = bus.req1_op1 + 16'h0010;
            else bus.req0_op1 = bus.req0_op1 + 16'h0010;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req1_valid = 1'b0;
        set_req(1'b0, OPC_ADD, 16'h0001, 16'h0001, COND_AL);
        set_req(1'b1, OPC_ADD, 16'h0001, 16'h0001, COND_AL);
        bus.req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 0);
        chk("rst_rsp_executed", 32'(bus.rsp_executed), 0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'(OPC_NOP));
        chk("rst_alu_ops", 32'({alu_op1, alu_op2}), 0);
        chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req0_valid = 1'b0;

        // Basic issue and latency
        drive_one(1'b0, OPC_ADD, 16'd3, 16'd4, COND_AL);
        @(negedge clk);
        chk("t1_exec_opcode", 32'(alu_opcode), 32'(OPC_ADD));
        chk("t1_exec_ops", 32'({alu_op1, alu_op2}), 32'h0003_0004);
        chk("t1_exec_imm", 32'(alu_imm), 32'h03);
        @(negedge clk);
        chk("t1_capt_nop", 32'(alu_opcode), 32'(OPC_NOP));
        chk("t1_capt_no_rsp", 32'(bus.rsp_valid), 0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
        wait_drain();

        // Conditional pairs on the compare result
        drive_one(1'b0, OPC_CMP, 16'd5, 16'd5, COND_AL);
        drive_one(1'b0, OPC_SUB, 16'd9, 16'd2, COND_EQ);
        wait_drain();
        drive_one(1'b1, OPC_CMP, 16'd5, 16'd5, COND_AL);
        drive_one(1'b1, OPC_SUB, 16'd9, 16'd2, COND_NE);
        @(negedge clk);
        chk("t3_skip_nop", 32'(alu_opcode), 32'(OPC_NOP));
        chk("t3_skip_ops", 32'({alu_op1, alu_op2}), 0);
        wait_drain();
        chk("t3_flags_kept", 32'({alu_n, alu_z, alu_c, alu_v}), 32'h6);

        // Overflow then VS / VC
        drive_one(1'b0, OPC_ADD, 16'h7FFF, 16'h0001, COND_AL);
        drive_one(1'b0, OPC_MOV, 16'h1234, 16'h0000, COND_VS);
        drive_one(1'b1, OPC_ADD, 16'h0001, 16'h0001, COND_VC);
        wait_drain();
        chk("t4_v_set", 32'(alu_v), 1);

        // Response stall blocks further grants
        bus.rsp_ready = 1'b0;
        drive_one(1'b0, OPC_ADD, 16'd10, 16'd20, COND_AL);
        set_req(1'b1, OPC_SUB, 16'd50, 16'd8, COND_AL);
        predict(1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.rsp_valid), 1);
            chk("stall_result", 32'(bus.rsp_result), 32'(exp_q[0].res));
            chk("stall_no_gnt", 32'(bus.req1_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_gnt(1'b1);
        bus.req1_valid = 1'b0;
        wait_drain();

        // Contention alternates 0,1,0,1
        drive_both(4);
        wait_drain();

        // Reset during CAPT restores rr_ptr to req0
        drive_both(3);
        drive_one(1'b1, OPC_ADD, 16'd2, 16'd3, COND_AL);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        mrr = 1'b0;
        @(negedge clk);
        chk("t5_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("t5_alu_nop", 32'(alu_opcode), 32'(OPC_NOP));
        chk("t5_rsp_cleared", 32'({bus.rsp_result, bus.rsp_executed}), 0);
        @(negedge clk);
        chk("t5_no_late_rsp", 32'(bus.rsp_valid), 0);
        chk("t5_queue", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        drive_both(1);
        wait_drain();

        // Cond 15 with all flags clear
        drive_one(1'b0, OPC_ADD, 16'd1, 16'd1, COND_AL);
        wait_drain();
        chk("t6_flags_zero", 32'({alu_n, alu_z, alu_c, alu_v}), 0);
        drive_one(1'b1, OPC_MOV, 16'h0055, 16'h0000, 4'd15);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
